// File: rtl/fpt_relay_pkg.sv
// Shared types and frame packing for the relay UART transmitter.
package fpt_relay_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_e;

  localparam int FRAME_BYTES = 5;
  localparam int EVT_W       = 19;

  function automatic logic [7:0] frame_csum(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3);
    return b0 ^ b1 ^ b2 ^ b3;
  endfunction

  // evt layout is {veto, attention[1:0], correction[15:0]}.
  function automatic logic [7:0] frame_byte(input logic [7:0]       sync,
                                            input logic [EVT_W-1:0] evt,
                                            input logic [3:0]       seq,
                                            input logic [2:0]       idx);
    logic [7:0] b1;
    b1 = {seq, 1'b0, evt[18:16]};
    case (idx)
      3'd0:    return sync;
      3'd1:    return b1;
      3'd2:    return evt[15:8];
      3'd3:    return evt[7:0];
      default: return frame_csum(sync, b1, evt[15:8], evt[7:0]);
    endcase
  endfunction

endpackage

// File: rtl/fpt_relay_uart_tx_fifo.sv
// Small synchronous FIFO; pushes while full and pops while empty are ignored.
module fpt_sync_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/fpt_relay_uart_tx.sv
// Relay telemetry transmitter: queues FPT decision events and sends each as a
// 5-byte checksummed 8N1 frame.
module fpt_relay_uart_tx
  import fpt_relay_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic        clk_100mhz,
  input  logic        rst,
  input  logic        evt_valid,
  output logic        evt_ready,
  input  logic        evt_veto,
  input  logic [1:0]  evt_attention,
  input  logic [15:0] evt_correction,
  output logic        uart_txd,
  output logic        busy,
  output logic [7:0]  drop_count
);
  localparam int            BW      = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_TC = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_B  = 3'(FRAME_BYTES - 1);

  state_e            state_q, state_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [2:0]        bit_q, bit_d, byte_q, byte_d;
  logic [3:0]        seq_q, seq_d;
  logic [EVT_W-1:0]  evt_q, evt_d, fifo_dout;
  logic              txd_q, txd_d, busy_q, busy_d;
  logic [7:0]        drop_q;
  logic              fifo_full, fifo_empty, pop, baud_tc;
  logic [7:0]        cur_byte;

  fpt_sync_fifo #(.WIDTH(EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_100mhz),
    .rst_i   (rst),
    .push_i  (evt_valid),
    .pop_i   (pop),
    .din_i   ({evt_veto, evt_attention, evt_correction}),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign evt_ready  = ~fifo_full;
  assign uart_txd   = txd_q;
  assign busy       = busy_q;
  assign drop_count = drop_q;
  assign baud_tc    = (baud_q == BAUD_TC);
  // seq_q only changes between frames, so bytes can be built on the fly.
  assign cur_byte   = frame_byte(SYNC_BYTE, evt_q, seq_q, byte_q);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    seq_d   = seq_q;
    evt_d   = evt_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          evt_d   = fifo_dout;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        busy_d  = 1'b1;
        byte_d  = '0;
        baud_d  = '0;
        txd_d   = 1'b0;
        state_d = START;
      end
      START: begin
        baud_d = baud_q + BW'(1);
        if (baud_tc) begin
          baud_d  = '0;
          bit_d   = '0;
          txd_d   = cur_byte[0];
          state_d = DATA;
        end
      end
      DATA: begin
        baud_d = baud_q + BW'(1);
        if (baud_tc) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = cur_byte[bit_d];
          end
        end
      end
      STOP: begin
        baud_d = baud_q + BW'(1);
        if (baud_tc) begin
          baud_d = '0;
          if (byte_q != LAST_B) begin
            byte_d  = byte_q + 3'd1;
            txd_d   = 1'b0;
            state_d = START;
          end else begin
            seq_d = seq_q + 4'd1;
            // Chain straight into the next frame; txd stays high through LOAD.
            if (!fifo_empty) begin
              pop     = 1'b1;
              evt_d   = fifo_dout;
              state_d = LOAD;
            end else begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      seq_q   <= '0;
      evt_q   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      seq_q   <= seq_d;
      evt_q   <= evt_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst)                                          drop_q <= '0;
    else if (evt_valid && fifo_full && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
  end

endmodule

// File: tb/tb_fpt_relay_uart_tx.sv
// Directed bench for fpt_relay_uart_tx with a line-level 8N1 frame receiver.
module tb_fpt_relay_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clk_100mhz = 1'b0;
  logic        rst = 1'b1;
  logic        evt_valid = 1'b0;
  logic        evt_veto = 1'b0;
  logic [1:0]  evt_attention = '0;
  logic [15:0] evt_correction = '0;
  logic        evt_ready, uart_txd, busy;
  logic [7:0]  drop_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk_100mhz = ~clk_100mhz;
  always @(posedge clk_100mhz) cyc <= cyc + 1;

  fpt_relay_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
    .clk_100mhz     (clk_100mhz),
    .rst            (rst),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_veto       (evt_veto),
    .evt_attention  (evt_attention),
    .evt_correction (evt_correction),
    .uart_txd       (uart_txd),
    .busy           (busy),
    .drop_count     (drop_count)
  );

  typedef struct {
    logic        v;
    logic [1:0]  a;
    logic [15:0] c;
    logic [39:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] model(input logic v, input logic [1:0] a,
                                        input logic [15:0] c, input logic [3:0] s);
    logic [7:0] b1;
    b1 = {s, 1'b0, v, a};
    return {8'hA5, b1, c[15:8], c[7:0], 8'hA5 ^ b1 ^ c[15:8] ^ c[7:0]};
  endfunction

  function automatic logic [15:0] ev_c(input int k);
    return 16'(16'h1111 * (k + 1));
  endfunction

  task automatic do_reset();
    @(posedge clk_100mhz); #1 rst = 1'b1;
    repeat (2) @(posedge clk_100mhz);
    #1 rst = 1'b0;
  endtask

  task automatic send_evt(input logic v, input logic [1:0] a, input logic [15:0] c);
    @(posedge clk_100mhz); #1;
    evt_valid = 1'b1; evt_veto = v; evt_attention = a; evt_correction = c;
    @(posedge clk_100mhz); #1;
    evt_valid = 1'b0;
  endtask

  // Samples mid-bit on falling clock edges; t is the cycle the start bit was seen.
  task automatic rx_byte(output logic [7:0] b, output bit ok, output int t);
    int n;
    ok = 1'b1; b = '0; t = 0; n = 0;
    @(negedge clk_100mhz);
    while (uart_txd !== 1'b0 && n < 3000) begin
      @(negedge clk_100mhz);
      n++;
    end
    if (n >= 3000) begin
      ok = 1'b0;
      return;
    end
    t = cyc;
    @(negedge clk_100mhz);
    if (uart_txd !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk_100mhz);
      b[i] = uart_txd;
    end
    repeat (CPB) @(negedge clk_100mhz);
    if (uart_txd !== 1'b1) ok = 1'b0;
  endtask

  task automatic rx_frame(output logic [39:0] f, output bit ok, output int t0);
    logic [7:0] b;
    bit bok;
    int t;
    ok = 1'b1; f = '0; t0 = 0;
    for (int i = 0; i < 5; i++) begin
      rx_byte(b, bok, t);
      if (i == 0) t0 = t;
      f = {f[31:0], b};
      if (!bok) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  vec_t vt [4];

  initial begin
    logic [39:0] f;
    bit ok;
    int t, tprev, viol;

    vt[0] = '{1'b1, 2'd2, 16'h1234, 40'hA5_06_12_34_85};
    vt[1] = '{1'b0, 2'd3, 16'hABCD, 40'hA5_13_AB_CD_D0};
    vt[2] = '{1'b1, 2'd0, 16'h0000, 40'hA5_24_00_00_81};
    vt[3] = '{1'b0, 2'd1, 16'hFFFF, 40'hA5_31_FF_FF_94};

    // Reset state and quiet idle line.
    repeat (2) @(posedge clk_100mhz);
    #1;
    chk("rst_txd", uart_txd, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", evt_ready, 1'b1);
    chk("rst_drop", drop_count, 8'd0);
    rst = 1'b0;
    viol = 0;
    repeat (1000) begin
      @(negedge clk_100mhz);
      if (uart_txd !== 1'b1 || busy !== 1'b0 || evt_ready !== 1'b1 || drop_count !== 8'd0) viol++;
    end
    chk("idle_hold", viol, 0);

    // Single frames with hand-computed bytes and latency checks.
    for (int i = 0; i < 4; i++) begin
      fork
        begin
          send_evt(vt[i].v, vt[i].a, vt[i].c);
          @(posedge clk_100mhz); #1;
          chk($sformatf("vec%0d_busy_load", i), busy, 1'b1);
          chk($sformatf("vec%0d_txd_load", i), uart_txd, 1'b1);
          @(posedge clk_100mhz); #1;
          chk($sformatf("vec%0d_txd_fall", i), uart_txd, 1'b0);
          repeat (199) @(posedge clk_100mhz);
          #1 chk($sformatf("vec%0d_busy_end", i), busy, 1'b1);
          @(posedge clk_100mhz);
          #1 chk($sformatf("vec%0d_busy_low", i), busy, 1'b0);
        end
        rx_frame(f, ok, t);
      join
      chk($sformatf("vec%0d_framing", i), ok, 1'b1);
      chk($sformatf("vec%0d_frame", i), f, vt[i].exp);
    end

    // Backpressure: six events on consecutive cycles, sixth dropped.
    do_reset();
    fork
      begin
        @(posedge clk_100mhz); #1;
        for (int i = 0; i < 6; i++) begin
          chk($sformatf("bp_ready%0d", i), evt_ready, (i < 5) ? 1'b1 : 1'b0);
          evt_valid = 1'b1; evt_veto = i[0]; evt_attention = i[1:0]; evt_correction = ev_c(i);
          @(posedge clk_100mhz); #1;
        end
        evt_valid = 1'b0;
        chk("bp_drop", drop_count, 8'd1);
      end
      begin
        logic [39:0] bf;
        bit bok;
        int bt, bprev;
        bprev = 0;
        for (int k = 0; k < 5; k++) begin
          rx_frame(bf, bok, bt);
          chk($sformatf("bp_frame%0d", k), bf, model(k[0], k[1:0], ev_c(k), 4'(k)));
          if (k > 0) chk($sformatf("bp_gap%0d", k), bt - bprev, 201);
          bprev = bt;
        end
      end
    join

    // Sequence number wraps after 16 frames.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      fork
        send_evt(i[0], i[2:1], 16'(i * 16'h0123 + 16'h00F0));
        rx_frame(f, ok, t);
      join
      chk($sformatf("wrap_frame%0d", i), f, model(i[0], i[2:1], 16'(i * 16'h0123 + 16'h00F0), 4'(i)));
      if (i == 15) chk("wrap_seq_f", f[31:28], 4'hF);
      if (i == 16) chk("wrap_seq_0", f[31:28], 4'h0);
    end

    // Drop counter saturates while queued frames still go out intact.
    do_reset();
    fork
      begin
        @(posedge clk_100mhz); #1;
        for (int i = 0; i < 5; i++) begin
          evt_valid = 1'b1; evt_veto = i[0]; evt_attention = i[1:0]; evt_correction = ev_c(i);
          @(posedge clk_100mhz); #1;
        end
        evt_veto = 1'b1; evt_attention = 2'd3; evt_correction = 16'hBEEF;
        repeat (300) @(posedge clk_100mhz);
        #1 evt_valid = 1'b0;
        chk("sat_drop", drop_count, 8'd255);
      end
      begin
        logic [39:0] sf;
        bit sok;
        int st;
        for (int k = 0; k < 6; k++) begin
          rx_frame(sf, sok, st);
          chk($sformatf("sat_frame%0d", k), sf,
              (k < 5) ? model(k[0], k[1:0], ev_c(k), 4'(k)) : model(1'b1, 2'd3, 16'hBEEF, 4'(k)));
        end
      end
    join

    // Reset in the middle of byte 2's data bits abandons the frame.
    send_evt(1'b1, 2'd1, 16'h5A5A);
    repeat (102) @(posedge clk_100mhz);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_txd", uart_txd, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_drop", drop_count, 8'd0);
    chk("mid_rst_ready", evt_ready, 1'b1);
    repeat (3) @(posedge clk_100mhz);
    #1 rst = 1'b0;
    viol = 0;
    repeat (300) begin
      @(negedge clk_100mhz);
      if (uart_txd !== 1'b1) viol++;
    end
    chk("mid_rst_quiet", viol, 0);
    fork
      send_evt(1'b0, 2'd2, 16'h0F0F);
      rx_frame(f, ok, t);
    join
    chk("post_rst_framing", ok, 1'b1);
    chk("post_rst_frame", f, model(1'b0, 2'd2, 16'h0F0F, 4'd0));
    chk("post_rst_drop", drop_count, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
